// File: rtl/ram_latency_model_if.sv
// Request/response bus between the memory controller and the RAM latency model.
// The controller holds a request level until it sees ACCESS or ERROR on ramstate.
interface ram_latency_model_if;
  logic [31:0] ramaddr;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport master (
    output ramaddr,
    output ramREN,
    output ramWEN,
    output ramstore,
    input  ramload,
    input  ramstate
  );

  modport slave (
    input  ramaddr,
    input  ramREN,
    input  ramWEN,
    input  ramstore,
    output ramload,
    output ramstate
  );
endinterface

// File: rtl/ram_latency_model.sv
// Word-addressed RAM with a programmable BUSY latency ahead of each one-word ACCESS,
// plus a backdoor port for preload and readback.
module ram_latency_model #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LAT   = 2
) (
  input  logic                CLK,
  input  logic                RST,
  ram_latency_model_if.slave  ram,
  input  logic                bk_en,
  input  logic                bk_wen,
  input  logic [31:0]         bk_addr,
  input  logic [31:0]         bk_wdata,
  output logic [31:0]         bk_rdata
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [31:0] LIMIT  = 32'(4 * DEPTH);
  localparam logic [3:0]  LAT_M1 = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

  typedef enum logic [1:0] {StFree, StBusy, StAccess, StError} ram_state_e;

  logic [31:0] mem [DEPTH];

  ram_state_e  state;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_vld_q, req_vld_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        req_wr_q, req_wr_d;
  logic        acc_q, acc_d;
  logic        active, err, new_req;
  logic [AW-1:0] idx, bk_idx;
  logic        bk_in;

  assign idx    = ram.ramaddr[AW+1:2];
  assign bk_idx = bk_addr[AW+1:2];
  assign bk_in  = bk_addr < LIMIT;

  always_comb begin
    active  = ram.ramREN | ram.ramWEN;
    err     = active & ((ram.ramREN & ram.ramWEN) | (ram.ramaddr[1:0] != 2'b00) |
                        (ram.ramaddr >= LIMIT));
    // Re-issuing the same request right after ACCESS starts a fresh word.
    new_req = active & ~err & (~req_vld_q | (ram.ramaddr != req_addr_q) |
                               (ram.ramWEN != req_wr_q) | acc_q);

    state      = StFree;
    cnt_d      = cnt_q;
    req_vld_d  = req_vld_q;
    req_addr_d = req_addr_q;
    req_wr_d   = req_wr_q;
    acc_d      = 1'b0;

    if (!active) begin
      req_vld_d = 1'b0;
      cnt_d     = 4'd0;
    end else if (err) begin
      state      = StError;
      req_vld_d  = 1'b0;
      req_addr_d = 32'd0;
      req_wr_d   = 1'b0;
      cnt_d      = 4'd0;
    end else if (new_req) begin
      req_vld_d  = 1'b1;
      req_addr_d = ram.ramaddr;
      req_wr_d   = ram.ramWEN;
      if (LAT == 0) begin
        state = StAccess;
        acc_d = 1'b1;
        cnt_d = 4'd0;
      end else begin
        state = StBusy;
        cnt_d = LAT_M1;
      end
    end else if (cnt_q != 4'd0) begin
      state = StBusy;
      cnt_d = cnt_q - 4'd1;
    end else begin
      state = StAccess;
      acc_d = 1'b1;
    end

    // Outputs read FREE for as long as reset is held, even with a request pending.
    if (RST) state = StFree;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q      <= 4'd0;
      req_vld_q  <= 1'b0;
      req_addr_q <= 32'd0;
      req_wr_q   <= 1'b0;
      acc_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      req_vld_q  <= req_vld_d;
      req_addr_q <= req_addr_d;
      req_wr_q   <= req_wr_d;
      acc_q      <= acc_d;
    end
  end

  // Request writes win; backdoor writes only land while the bus is idle.
  always_ff @(posedge CLK) begin
    if (state == StAccess && ram.ramWEN) begin
      mem[idx] <= ram.ramstore;
    end else if (bk_en && bk_wen && !active && bk_in) begin
      mem[bk_idx] <= bk_wdata;
    end
  end

  assign ram.ramstate = state;
  assign ram.ramload  = (state == StAccess && !ram.ramWEN) ? mem[idx] : 32'd0;
  assign bk_rdata     = bk_in ? mem[bk_idx] : 32'd0;

endmodule

// File: tb/tb_ram_latency_model.sv
// Directed bench for ram_latency_model: LAT=2, LAT=3 and LAT=0 instances side by side.
module tb_ram_latency_model;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  ram_latency_model_if i2 ();
  ram_latency_model_if i3 ();
  ram_latency_model_if i0 ();

  logic        b2_en, b2_wen, b3_en, b3_wen, b0_en, b0_wen;
  logic [31:0] b2_addr, b2_wdata, b2_rdata;
  logic [31:0] b3_addr, b3_wdata, b3_rdata;
  logic [31:0] b0_addr, b0_wdata, b0_rdata;

  ram_latency_model #(.DEPTH(64), .LAT(2)) dut2 (
    .CLK(CLK), .RST(RST), .ram(i2.slave), .bk_en(b2_en), .bk_wen(b2_wen),
    .bk_addr(b2_addr), .bk_wdata(b2_wdata), .bk_rdata(b2_rdata));
  ram_latency_model #(.DEPTH(64), .LAT(3)) dut3 (
    .CLK(CLK), .RST(RST), .ram(i3.slave), .bk_en(b3_en), .bk_wen(b3_wen),
    .bk_addr(b3_addr), .bk_wdata(b3_wdata), .bk_rdata(b3_rdata));
  ram_latency_model #(.DEPTH(64), .LAT(0)) dut0 (
    .CLK(CLK), .RST(RST), .ram(i0.slave), .bk_en(b0_en), .bk_wen(b0_wen),
    .bk_addr(b0_addr), .bk_wdata(b0_wdata), .bk_rdata(b0_rdata));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask

  task automatic bk2_write(input logic [31:0] a, input logic [31:0] d);
    b2_en = 1'b1; b2_wen = 1'b1; b2_addr = a; b2_wdata = d;
    cyc();
    b2_en = 1'b0; b2_wen = 1'b0;
  endtask

  task automatic bk3_write(input logic [31:0] a, input logic [31:0] d);
    b3_en = 1'b1; b3_wen = 1'b1; b3_addr = a; b3_wdata = d;
    cyc();
    b3_en = 1'b0; b3_wen = 1'b0;
  endtask

  task automatic bk0_write(input logic [31:0] a, input logic [31:0] d);
    b0_en = 1'b1; b0_wen = 1'b1; b0_addr = a; b0_wdata = d;
    cyc();
    b0_en = 1'b0; b0_wen = 1'b0;
  endtask

  task automatic req2(input logic ren, input logic wen, input logic [31:0] a,
                      input logic [31:0] d);
    i2.ramREN = ren; i2.ramWEN = wen; i2.ramaddr = a; i2.ramstore = d;
  endtask

  task automatic req3(input logic ren, input logic wen, input logic [31:0] a,
                      input logic [31:0] d);
    i3.ramREN = ren; i3.ramWEN = wen; i3.ramaddr = a; i3.ramstore = d;
  endtask

  logic [1:0]  burst_st [6];
  logic [31:0] burst_ld [6];

  initial begin
    RST = 1'b1;
    req2(1'b0, 1'b0, 32'h0, 32'h0);
    req3(1'b0, 1'b0, 32'h0, 32'h0);
    i0.ramREN = 1'b0; i0.ramWEN = 1'b0; i0.ramaddr = 32'h0; i0.ramstore = 32'h0;
    {b2_en, b2_wen, b3_en, b3_wen, b0_en, b0_wen} = '0;
    b2_addr = '0; b2_wdata = '0; b3_addr = '0; b3_wdata = '0; b0_addr = '0; b0_wdata = '0;

    // Reset state
    cyc();
    check("rst_state2", i2.ramstate, FREE);
    check("rst_load2", i2.ramload, 32'h0);
    check("rst_state3", i3.ramstate, FREE);
    check("rst_state0", i0.ramstate, FREE);
    RST = 1'b0;
    cyc();

    bk2_write(32'h00, 32'h5A5A5A5A);
    bk2_write(32'h10, 32'hDEADBEEF);
    bk2_write(32'h24, 32'h11111111);
    bk2_write(32'h30, 32'h30303030);
    bk2_write(32'h40, 32'hA0A00040);
    bk2_write(32'h44, 32'hB0B00044);
    b2_addr = 32'h10; #1;
    check("bk_preload", b2_rdata, 32'hDEADBEEF);

    // 1: LAT=2 read
    req2(1'b1, 1'b0, 32'h10, 32'h0); #2;
    check("t1_c0_state", i2.ramstate, BUSY);
    check("t1_c0_load", i2.ramload, 32'h0);
    cyc(); #2;
    check("t1_c1_state", i2.ramstate, BUSY);
    cyc(); #2;
    check("t1_c2_state", i2.ramstate, ACCESS);
    check("t1_c2_load", i2.ramload, 32'hDEADBEEF);
    cyc();
    req2(1'b0, 1'b0, 32'h10, 32'h0); #2;
    check("t1_after_state", i2.ramstate, FREE);
    check("t1_after_load", i2.ramload, 32'h0);
    cyc();

    // 2: write then read; backdoor write during the request must be dropped
    req2(1'b0, 1'b1, 32'h20, 32'h12345678);
    b2_en = 1'b1; b2_wen = 1'b1; b2_addr = 32'h24; b2_wdata = 32'h99999999; #2;
    check("t2_w0_state", i2.ramstate, BUSY);
    cyc();
    b2_en = 1'b0; b2_wen = 1'b0; #2;
    check("t2_w1_state", i2.ramstate, BUSY);
    cyc(); #2;
    check("t2_w2_state", i2.ramstate, ACCESS);
    check("t2_w2_load", i2.ramload, 32'h0);
    cyc();
    req2(1'b0, 1'b0, 32'h20, 32'h0);
    b2_addr = 32'h20; #1;
    check("t2_bk_after_write", b2_rdata, 32'h12345678);
    b2_addr = 32'h24; #1;
    check("t2_bk_dropped", b2_rdata, 32'h11111111);
    req2(1'b1, 1'b0, 32'h20, 32'h0);
    cyc(); #2;
    check("t2_r1_state", i2.ramstate, BUSY);
    cyc(); #2;
    check("t2_r2_state", i2.ramstate, ACCESS);
    check("t2_r2_load", i2.ramload, 32'h12345678);
    cyc();

    // 3: burst 0x40, 0x44 back-to-back
    burst_st = '{BUSY, BUSY, ACCESS, BUSY, BUSY, ACCESS};
    burst_ld = '{32'h0, 32'h0, 32'hA0A00040, 32'h0, 32'h0, 32'hB0B00044};
    for (int i = 0; i < 6; i++) begin
      req2(1'b1, 1'b0, (i < 3) ? 32'h40 : 32'h44, 32'h0); #2;
      check($sformatf("t3_state%0d", i), i2.ramstate, burst_st[i]);
      check($sformatf("t3_load%0d", i), i2.ramload, burst_ld[i]);
      cyc();
    end
    req2(1'b0, 1'b0, 32'h0, 32'h0);
    cyc();

    // 4: LAT=3 address change mid-BUSY, read then write variant
    bk3_write(32'h80, 32'h80808080);
    bk3_write(32'h84, 32'h84848484);
    req3(1'b1, 1'b0, 32'h80, 32'h0); #2;
    check("t4r_first", i3.ramstate, BUSY);
    cyc();
    for (int i = 0; i < 4; i++) begin
      req3(1'b1, 1'b0, 32'h84, 32'h0); #2;
      check($sformatf("t4r_state%0d", i), i3.ramstate, (i == 3) ? ACCESS : BUSY);
      cyc();
    end
    req3(1'b1, 1'b0, 32'h84, 32'h0);
    req3(1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    req3(1'b0, 1'b1, 32'h80, 32'hFFFF0000); #2;
    check("t4w_first", i3.ramstate, BUSY);
    cyc();
    for (int i = 0; i < 4; i++) begin
      req3(1'b0, 1'b1, 32'h84, 32'h0BADF00D); #2;
      check($sformatf("t4w_state%0d", i), i3.ramstate, (i == 3) ? ACCESS : BUSY);
      cyc();
    end
    req3(1'b0, 1'b0, 32'h0, 32'h0);
    b3_addr = 32'h80; #1;
    check("t4w_80_untouched", b3_rdata, 32'h80808080);
    b3_addr = 32'h84; #1;
    check("t4w_84_written", b3_rdata, 32'h0BADF00D);
    cyc();

    // 4b: LAT=3 read of 0x84 returns the new word after the full count
    req3(1'b1, 1'b0, 32'h84, 32'h0);
    cyc(); cyc(); cyc(); #2;
    check("t4_read84_load", i3.ramload, 32'h0BADF00D);
    cyc();
    req3(1'b0, 1'b0, 32'h0, 32'h0);
    cyc();

    // 5: error cases
    req2(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF); #2;
    check("t5_both_state", i2.ramstate, ERROR);
    check("t5_both_load", i2.ramload, 32'h0);
    cyc();
    req2(1'b1, 1'b0, 32'h2, 32'h0); #2;
    check("t5_misalign_state", i2.ramstate, ERROR);
    check("t5_misalign_load", i2.ramload, 32'h0);
    cyc();
    req2(1'b0, 1'b1, 32'd256, 32'hEEEEEEEE); #2;
    check("t5_range_state", i2.ramstate, ERROR);
    cyc();
    req2(1'b0, 1'b0, 32'h0, 32'h0);
    b2_addr = 32'h0; #1;
    check("t5_mem0_untouched", b2_rdata, 32'h5A5A5A5A);
    b2_addr = 32'd256; #1;
    check("t5_bk_oor_zero", b2_rdata, 32'h0);
    // Error in the middle of a request drops the latched count
    req2(1'b1, 1'b0, 32'h10, 32'h0);
    cyc();
    req2(1'b1, 1'b0, 32'h12, 32'h0); #2;
    check("t5_mid_err", i2.ramstate, ERROR);
    cyc();
    req2(1'b1, 1'b0, 32'h10, 32'h0); #2;
    check("t5_restart0", i2.ramstate, BUSY);
    cyc(); #2;
    check("t5_restart1", i2.ramstate, BUSY);
    cyc(); #2;
    check("t5_restart2", i2.ramstate, ACCESS);
    cyc();
    req2(1'b0, 1'b0, 32'h0, 32'h0);
    cyc();

    // 6: reset during a write's BUSY
    req2(1'b0, 1'b1, 32'h30, 32'hCAFEF00D); #2;
    check("t6_busy", i2.ramstate, BUSY);
    cyc();
    RST = 1'b1; #1;
    check("t6_rst_state", i2.ramstate, FREE);
    check("t6_rst_load", i2.ramload, 32'h0);
    cyc(); cyc();
    RST = 1'b0;
    b2_addr = 32'h30; #1;
    check("t6_mem_unchanged", b2_rdata, 32'h30303030);
    check("t6_post0", i2.ramstate, BUSY);
    cyc(); #2;
    check("t6_post1", i2.ramstate, BUSY);
    cyc(); #2;
    check("t6_post2", i2.ramstate, ACCESS);
    cyc();
    req2(1'b0, 1'b0, 32'h0, 32'h0); #1;
    check("t6_mem_written", b2_rdata, 32'hCAFEF00D);
    cyc();

    // LAT=0: zero-wait read and write
    bk0_write(32'h10, 32'h00000077);
    i0.ramREN = 1'b1; i0.ramaddr = 32'h10; #2;
    check("l0_read_state", i0.ramstate, ACCESS);
    check("l0_read_load", i0.ramload, 32'h00000077);
    cyc(); #2;
    check("l0_read_again", i0.ramstate, ACCESS);
    cyc();
    i0.ramREN = 1'b0; i0.ramWEN = 1'b1; i0.ramaddr = 32'h14; i0.ramstore = 32'h00001414; #2;
    check("l0_write_state", i0.ramstate, ACCESS);
    cyc();
    i0.ramWEN = 1'b0;
    b0_addr = 32'h14; #1;
    check("l0_write_mem", b0_rdata, 32'h00001414);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_latency_model.md
Name: ram_latency_model

Overview:
- Word-addressed data/instruction RAM sitting directly downstream of the coherence/arbitration memory controller.
- Consumes the controller's single RAM request bus (ramaddr, ramREN, ramWEN, ramstore) and returns ramload plus a ramstate handshake (FREE/BUSY/ACCESS/ERROR) with programmable access latency.
- Used in simulation and synthesis to exercise controller wait-state and burst (two-word block) sequencing.
- Provides a backdoor port for bench preload and readback.

Parameters:
- DEPTH, 1024: number of 32-bit words; must be a power of two.
- LAT, 2: BUSY cycles before ACCESS; legal range 0..15. 0 means zero-wait.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- ramaddr  input  32  byte address
- ramREN  input  1  read request, level held by master until ACCESS
- ramWEN  input  1  write request, level held by master until ACCESS
- ramstore  input  32  write data, sampled in the ACCESS cycle
- ramload  output  32  read data, valid only while ramstate==ACCESS on a read
- ramstate  output  2  FREE=2'd0, BUSY=2'd1, ACCESS=2'd2, ERROR=2'd3
- bk_en  input  1  backdoor access enable, bench only
- bk_wen  input  1  backdoor write (1) / read (0)
- bk_addr  input  32  backdoor byte address
- bk_wdata  input  32  backdoor write data
- bk_rdata  output  32  backdoor read data, combinational from the array

Behaviour:
Reset and registers
- Reset is asynchronous, active-high. It clears cnt to 0, req_vld to 0, req_addr to 0 and req_wr to 0.
- During and after reset: ramstate=FREE and ramload=0. Array contents are not reset.

Request classification and decode
- A request is active when ramREN|ramWEN is high.
- Index = ramaddr[log2(DEPTH)+1:2].
- ERROR is combinational, with priority over everything else. It is raised when:
  - ramREN & ramWEN are both high, or
  - ramaddr[1:0]!=0, or
  - ramaddr >= 4*DEPTH.
- In ERROR: no write occurs, ramload=0, the latched request is cleared and cnt=0.
- A new request is an active, non-error request where any of these holds:
  - req_vld==0,
  - ramaddr!=req_addr,
  - ramWEN!=req_wr,
  - the previous cycle was ACCESS.

Latency state machine (registered state is cnt plus the latched request)
- FREE: no active request. req_vld is cleared at the next edge.
- New request, LAT==0: ramstate=ACCESS in the same cycle.
- New request, LAT>0: ramstate=BUSY. Latch addr/op at the edge, set req_vld=1, cnt=LAT-1.
- Continuing request with cnt>0: BUSY, cnt decrements each edge.
- Continuing request with cnt==0: ACCESS for exactly one cycle.
- Changing address or op mid-BUSY abandons the old request and restarts the full LAT count. No partial write occurs.
- Request dropped mid-BUSY: FREE next cycle, no side effects.
- Holding the same request after ACCESS counts as a new request and restarts LAT. Each ACCESS completes exactly one word.
- Net latency: a request held from cycle t sees ACCESS in cycle t+LAT.

Data path
- Read in ACCESS: ramload = mem[index], combinational.
- Write in ACCESS: mem[index] <= ramstore at the edge closing the ACCESS cycle. A read of the same word in the next request returns the new data.
- ramload=0 in every non-ACCESS state.

Backdoor
- bk_rdata = mem[bk_addr index] at all times.
- bk_en & bk_wen writes at the clock edge only when no request is active. Otherwise the backdoor write is dropped.
- Out-of-range bk_addr: writes are ignored and bk_rdata=0.

Burst pattern
- The controller issues A then A+4 back-to-back.
- Required sequence: BUSY×LAT, ACCESS, BUSY×LAT, ACCESS. No idle cycle is inserted between them.

Test Plan:
1. LAT=2: preload mem[0x10>>2]=0xDEADBEEF, hold ramREN with ramaddr=0x10 from cycle 0 -> ramstate BUSY in cycles 0 and 1, ACCESS in cycle 2 with ramload=0xDEADBEEF, then ramload=0.
2. LAT=2: write 0x12345678 to 0x20 held until ACCESS, then read 0x20 -> bk_rdata=0x12345678 after the write ACCESS edge; the read ACCESS returns 0x12345678.
3. LAT=2: read burst 0x40 then 0x44 with the address switched the cycle after ACCESS -> states B,B,A,B,B,A; each ACCESS returns the respective preloaded word.
4. LAT=3: change ramaddr 0x80 to 0x84 after 1 BUSY cycle -> count restarts, ACCESS occurs 3 cycles after the change, returns mem[0x84]; mem[0x80] untouched on a write variant.
5. ERROR cases, each -> ERROR the same cycle, no array change, ramload=0:
   - ramREN=ramWEN=1 at 0x0
   - ramaddr=0x2
   - ramaddr=4*DEPTH
6. Assert RST during BUSY of a write to 0x30 -> ramstate=FREE immediately, mem[0x30] unchanged; after release, the same request takes the full LAT again. LAT=0 build: ACCESS in the first request cycle.
